// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-drive and result bundle for alu_issue_ctrl.
// master is the environment (command source, ALU, result sink); slave is the controller.
interface alu_issue_ctrl_if;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned RES_W = 16;
    localparam int unsigned ISS_W = 8;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_opcode;
    logic [DAT_W-1:0] cmd_a;
    logic [DAT_W-1:0] cmd_b;
    logic             cmd_ex_sel;

    logic             alu_init;
    logic [OP_W-1:0]  alu_opcode;
    logic [DAT_W-1:0] alu_a;
    logic [DAT_W-1:0] alu_b;
    logic             alu_ex_sel;
    logic [RES_W-1:0] alu_y;

    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_data;
    logic [OP_W-1:0]  res_opcode;

    logic             busy;
    logic [ISS_W-1:0] issue_count;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_ex_sel, alu_y, res_ready,
        input  cmd_ready, alu_init, alu_opcode, alu_a, alu_b, alu_ex_sel,
               res_valid, res_data, res_opcode, busy, issue_count
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_ex_sel, alu_y, res_ready,
        output cmd_ready, alu_init, alu_opcode, alu_a, alu_b, alu_ex_sel,
               res_valid, res_data, res_opcode, busy, issue_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Queues ALU commands in a small FIFO and issues them one at a time to a fixed-latency ALU,
// holding each result until the consumer accepts it.
module alu_issue_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DAT_W  = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned ISS_W  = 8;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [DAT_W-1:0] a;
        logic [DAT_W-1:0] b;
        logic             ex_sel;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;

    cmd_t              mem [DEPTH];
    cmd_t              cmd_in;
    cmd_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              push;

    logic              pop;
    logic              capture;
    logic              alu_init_d;

    logic [WAIT_W-1:0] wait_cnt;
    logic              alu_init_q;
    logic [OP_W-1:0]   alu_opcode_q;
    logic [DAT_W-1:0]  alu_a_q;
    logic [DAT_W-1:0]  alu_b_q;
    logic              alu_ex_sel_q;
    logic              res_valid_q;
    logic [RES_W-1:0]  res_data_q;
    logic [OP_W-1:0]   res_opcode_q;
    logic [ISS_W-1:0]  issue_count_q;

    assign cmd_in     = {bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_ex_sel};
    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);

    // Ready looks only at the registered count, so a pop at full never frees a slot the same edge.
    assign bus.cmd_ready = (count < CNT_W'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign bus.busy      = (state != ST_IDLE) || !fifo_empty;

    assign bus.alu_init    = alu_init_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_ex_sel  = alu_ex_sel_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_opcode  = res_opcode_q;
    assign bus.issue_count = issue_count_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (!fifo_empty)                   state_d = ST_WAIT;
            ST_WAIT:   if (wait_cnt == WAIT_W'(1))        state_d = ST_RESULT;
            ST_RESULT: if (bus.res_ready)                 state_d = ST_IDLE;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath
    always_comb begin
        pop        = 1'b0;
        capture    = 1'b0;
        alu_init_d = 1'b0;
        case (state)
            ST_IDLE:   pop     = !fifo_empty;
            ST_WAIT:   capture = (wait_cnt == WAIT_W'(1));
            default:   ;
        endcase
        alu_init_d = (state_d != ST_IDLE);
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_in;
    end

    // ALU drive, latency counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= '0;
            alu_init_q    <= 1'b0;
            alu_opcode_q  <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ex_sel_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_opcode_q  <= '0;
            issue_count_q <= '0;
        end else begin
            alu_init_q <= alu_init_d;
            if (pop) begin
                alu_opcode_q  <= head.opcode;
                alu_a_q       <= head.a;
                alu_b_q       <= head.b;
                alu_ex_sel_q  <= head.ex_sel;
                wait_cnt      <= WAIT_W'(LAT);
                issue_count_q <= issue_count_q + ISS_W'(1);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (capture) begin
                res_data_q   <= bus.alu_y;
                res_opcode_q <= alu_opcode_q;
                res_valid_q  <= 1'b1;
            end else if (state == ST_RESULT && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: a LAT=1 and a LAT=3 instance checked against
// an in-order command queue and the ALU stub's arithmetic.
module tb_alu_issue_ctrl;
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ex;
    } tcmd_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int unsigned accepted = 0;
    tcmd_t exp_q[$];

    alu_issue_ctrl_if bus();
    alu_issue_ctrl_if bus3();

    alu_issue_ctrl #(.DEPTH(4), .LAT(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_issue_ctrl #(.DEPTH(4), .LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    always #5 clk = ~clk;

    // ALU stub: sum of operands, or the operands concatenated when ex_sel is set
    assign bus.alu_y  = bus.alu_ex_sel  ? {bus.alu_a,  bus.alu_b}  : (16'(bus.alu_a)  + 16'(bus.alu_b));
    assign bus3.alu_y = bus3.alu_ex_sel ? {bus3.alu_a, bus3.alu_b} : (16'(bus3.alu_a) + 16'(bus3.alu_b));

    function automatic logic [15:0] exp_y(input tcmd_t c);
        return c.ex ? {c.a, c.b} : (16'(c.a) + 16'(c.b));
    endfunction

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        c.op = 4'($urandom);
        c.a  = 8'($urandom);
        c.b  = 8'($urandom);
        c.ex = 1'($urandom);
        return c;
    endfunction

    function automatic logic [52:0] outs1();
        return {bus.alu_init, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_ex_sel, bus.res_valid,
                bus.res_data, bus.res_opcode, bus.issue_count, bus.busy, bus.cmd_ready};
    endfunction

    function automatic logic [52:0] outs3();
        return {bus3.alu_init, bus3.alu_opcode, bus3.alu_a, bus3.alu_b, bus3.alu_ex_sel, bus3.res_valid,
                bus3.res_data, bus3.res_opcode, bus3.issue_count, bus3.busy, bus3.cmd_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command on the LAT=1 instance, waiting (bounded) for ready.
    task automatic push_cmd(input tcmd_t c);
        int n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = c.op;
        bus.cmd_a      = c.a;
        bus.cmd_b      = c.b;
        bus.cmd_ex_sel = c.ex;
        while (bus.cmd_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
        end else begin
            tick();
            exp_q.push_back(c);
            accepted++;
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for a result, compare it with the queue head, stall a while, then accept it.
    task automatic collect_one(input int stall_min, input int stall_max);
        int    n = 0;
        int    stall;
        tcmd_t c;
        logic [15:0] ey;
        bus.res_ready = 1'b0;
        while (bus.res_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        n_tests++;
        if (bus.res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL result_timeout: res_valid=%b after %0d cycles, required 1", bus.res_valid, n);
            return;
        end
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: data=%h op=%h with no command outstanding", bus.res_data, bus.res_opcode);
            c = '0;
        end else begin
            c = exp_q.pop_front();
        end
        ey = exp_y(c);
        n_tests++;
        if (bus.res_data !== ey || bus.res_opcode !== c.op) begin
            n_fail++;
            $display("FAIL result_value: data=%h op=%h, required data=%h op=%h", bus.res_data, bus.res_opcode, ey, c.op);
        end
        stall = $urandom_range(stall_max, stall_min);
        for (int i = 0; i < stall; i++) begin
            tick();
            n_tests++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== ey || bus.res_opcode !== c.op) begin
                n_fail++;
                $display("FAIL result_hold: cycle %0d valid=%b data=%h op=%h, required 1 %h %h",
                         i, bus.res_valid, bus.res_data, bus.res_opcode, ey, c.op);
            end
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    // Random stream with gaps and back-pressure; both sides run concurrently.
    task automatic run_stream(input int cnt);
        fork
            begin
                for (int i = 0; i < cnt; i++) begin
                    repeat ($urandom_range(2, 0)) tick();
                    push_cmd(rand_cmd());
                end
            end
            begin
                for (int j = 0; j < cnt; j++) collect_one(0, 3);
            end
        join
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;  bus.cmd_opcode = '0;  bus.cmd_a = '0;  bus.cmd_b = '0;
        bus.cmd_ex_sel = 1'b0; bus.res_ready = 1'b0;
        bus3.cmd_valid = 1'b0; bus3.cmd_opcode = '0; bus3.cmd_a = '0; bus3.cmd_b = '0;
        bus3.cmd_ex_sel = 1'b0; bus3.res_ready = 1'b0;
        #3;
        n_tests++;
        if (outs1() !== 53'h1) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1: got %h, required %h", outs1(), 53'h1);
        end
        n_tests++;
        if (outs3() !== 53'h1) begin
            n_fail++;
            $display("FAIL reset_outputs_lat3: got %h, required %h", outs3(), 53'h1);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        n_tests++;
        if (outs1() !== 53'h1) begin
            n_fail++;
            $display("FAIL idle_after_release: got %h, required %h", outs1(), 53'h1);
        end
    endtask

    task automatic test_basic();
        int n = 0;
        bus.res_ready  = 1'b1;
        bus.cmd_opcode = 4'h0;
        bus.cmd_a      = 8'h02;
        bus.cmd_b      = 8'h02;
        bus.cmd_ex_sel = 1'b0;
        bus.cmd_valid  = 1'b1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: cmd_ready=%b, required 1", bus.cmd_ready);
        end
        tick();
        accepted++;
        bus.cmd_valid = 1'b0;
        while (bus.res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL basic_latency: res_valid after %0d edges, required 2", n);
        end
        n_tests++;
        if (bus.res_data !== 16'h0004 || bus.res_opcode !== 4'h0 || bus.issue_count !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_result: data=%h op=%h issued=%0d, required 0004 0 1",
                     bus.res_data, bus.res_opcode, bus.issue_count);
        end
        tick();
        bus.res_ready = 1'b0;
        n_tests++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.alu_init !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: valid=%b busy=%b init=%b, required 0 0 0",
                     bus.res_valid, bus.busy, bus.alu_init);
        end
    endtask

    task automatic test_fifo_full();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(rand_cmd());
        n_tests++;
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ready: cmd_ready=%b busy=%b, required 0 1", bus.cmd_ready, bus.busy);
        end
        // A sixth command must be refused while the result is blocked
        bus.cmd_valid = 1'b1;
        bus.cmd_opcode = 4'hF; bus.cmd_a = 8'hEE; bus.cmd_b = 8'hDD; bus.cmd_ex_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL full_hold: cycle %0d cmd_ready=%b, required 0", i, bus.cmd_ready);
            end
        end
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) collect_one(0, 2);
        tick();
        n_tests++;
        if (bus.issue_count !== 8'(accepted) || exp_q.size() != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: issued=%0d left=%0d busy=%b, required %0d 0 0",
                     bus.issue_count, exp_q.size(), bus.busy, 8'(accepted));
        end
    endtask

    task automatic test_hold();
        push_cmd(rand_cmd());
        collect_one(10, 10);
        n_tests++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_clear: res_valid=%b after handshake, required 0", bus.res_valid);
        end
        tick();
        n_tests++;
        if (bus.res_valid !== 1'b0 || bus.alu_init !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle: valid=%b init=%b, required 0 0", bus.res_valid, bus.alu_init);
        end
    endtask

    task automatic test_wrap();
        int rem = 256 - int'(accepted % 256);
        run_stream(rem - 1);
        tick();
        n_tests++;
        if (bus.issue_count !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_255: issue_count=%0d, required 255", bus.issue_count);
        end
        run_stream(1);
        tick();
        n_tests++;
        if (bus.issue_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_0: issue_count=%0d, required 0", bus.issue_count);
        end
    endtask

    task automatic test_lat3();
        int n = 0;
        bus3.res_ready  = 1'b1;
        bus3.cmd_opcode = 4'hC;
        bus3.cmd_a      = 8'h02;
        bus3.cmd_b      = 8'h00;
        bus3.cmd_ex_sel = 1'b0;
        bus3.cmd_valid  = 1'b1;
        tick();
        bus3.cmd_valid = 1'b0;
        while (bus3.res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
            n_tests++;
            if ({bus3.alu_init, bus3.alu_opcode, bus3.alu_a, bus3.alu_b, bus3.alu_ex_sel} !==
                {1'b1, 4'hC, 8'h02, 8'h00, 1'b0}) begin
                n_fail++;
                $display("FAIL lat3_drive: edge %0d init=%b op=%h a=%h b=%h ex=%b, required 1 c 02 00 0",
                         n, bus3.alu_init, bus3.alu_opcode, bus3.alu_a, bus3.alu_b, bus3.alu_ex_sel);
            end
        end
        n_tests++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL lat3_latency: res_valid after %0d edges, required 4", n);
        end
        n_tests++;
        if (bus3.res_data !== 16'h0002 || bus3.res_opcode !== 4'hC) begin
            n_fail++;
            $display("FAIL lat3_result: data=%h op=%h, required 0002 c", bus3.res_data, bus3.res_opcode);
        end
        tick();
        bus3.res_ready = 1'b0;
        n_tests++;
        if (bus3.res_valid !== 1'b0 || bus3.alu_init !== 1'b0 || bus3.alu_opcode !== 4'hC || bus3.alu_a !== 8'h02) begin
            n_fail++;
            $display("FAIL lat3_after: valid=%b init=%b op=%h a=%h, required 0 0 c 02",
                     bus3.res_valid, bus3.alu_init, bus3.alu_opcode, bus3.alu_a);
        end
    endtask

    task automatic test_reset_mid();
        tcmd_t c;
        int    n = 0;
        bus3.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = rand_cmd();
            bus3.cmd_valid  = 1'b1;
            bus3.cmd_opcode = c.op;
            bus3.cmd_a      = c.a;
            bus3.cmd_b      = c.b;
            bus3.cmd_ex_sel = c.ex;
            tick();
        end
        bus3.cmd_valid = 1'b0;
        n_tests++;
        if (bus3.alu_init !== 1'b1 || bus3.res_valid !== 1'b0 || bus3.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: init=%b valid=%b ready=%b, required 1 0 1",
                     bus3.alu_init, bus3.res_valid, bus3.cmd_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (outs3() !== 53'h1) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h, required %h", outs3(), 53'h1);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_tests++;
            if (bus3.res_valid !== 1'b0 || bus3.busy !== 1'b0 || bus3.issue_count !== 8'd0 || bus.res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet: cycle %0d valid=%b busy=%b issued=%0d, required 0 0 0",
                         i, bus3.res_valid, bus3.busy, bus3.issue_count);
            end
        end
        // A fresh command after reset must be the only one that produces a result
        c = rand_cmd();
        bus3.res_ready  = 1'b1;
        bus3.cmd_valid  = 1'b1;
        bus3.cmd_opcode = c.op;
        bus3.cmd_a      = c.a;
        bus3.cmd_b      = c.b;
        bus3.cmd_ex_sel = c.ex;
        tick();
        bus3.cmd_valid = 1'b0;
        while (bus3.res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (bus3.res_valid !== 1'b1 || bus3.res_data !== exp_y(c) || bus3.res_opcode !== c.op || bus3.issue_count !== 8'd1) begin
            n_fail++;
            $display("FAIL midrst_recover: valid=%b data=%h op=%h issued=%0d, required 1 %h %h 1",
                     bus3.res_valid, bus3.res_data, bus3.res_opcode, bus3.issue_count, exp_y(c), c.op);
        end
        tick();
        bus3.res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_full();
        test_hold();
        test_wrap();
        test_lat3();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
